// File: rtl/jtag_gpr_master_pkg.sv
// Shared types and constants for the JTAG GPR access master and its halt timer.
// Build option: define JTAG_GPR_AUTOINC_EN to add the auto-incrementing address pointer.
package jtag_gpr_master_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_t;

    localparam reg_t      ZERO_WORD     = '0;
    localparam reg_addr_t ZERO_REG      = '0;
    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_t      data;
    } req_t;

    // x0 is hard-wired to zero, so the pointer wraps from 31 back to 1.
    function automatic reg_addr_t next_ptr(input reg_addr_t a);
        return (a == '1) ? reg_addr_t'(1) : a + reg_addr_t'(1);
    endfunction

endpackage

// File: rtl/jtag_halt_timer.sv
// Clear/enable cycle counter; o_tc flags the HALT_TIMEOUT-th enabled cycle.
module jtag_halt_timer #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [15:0] r_count;
    logic [16:0] w_count_next;

    assign w_count_next = {1'b0, r_count} + 17'd1;
    assign o_tc         = (w_count_next == 17'(HALT_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_count_next[15:0];
        end
    end

endmodule

// File: rtl/jtag_gpr_master.sv
// JTAG-side GPR initiator: halts the core, performs one GPR access, returns data/status.
// Build option: JTAG_GPR_AUTOINC_EN adds req_inc_i and an auto-incrementing address pointer.
module jtag_gpr_master
    import jtag_gpr_master_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [REG_ADDR_W-1:0] req_addr_i,
    input  logic [REG_W-1:0]      req_data_i,
`ifdef JTAG_GPR_AUTOINC_EN
    input  logic                  req_inc_i,
`endif
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [REG_W-1:0]      resp_data_o,
    output logic                  resp_err_o,
    output logic                  halt_req_o,
    input  logic                  halted_i,
    output logic                  jtag_we_o,
    output logic [REG_ADDR_W-1:0] jtag_addr_o,
    output logic [REG_W-1:0]      jtag_data_o,
    input  logic [REG_W-1:0]      jtag_data_i
);

    state_e    r_state;
    state_e    w_state_next;
    req_t      r_req;
    reg_t      r_resp_data;
    logic      r_resp_err;
    logic      w_accept;
    logic      w_tc;
    reg_addr_t w_addr_sel;

    assign w_accept = req_valid_i && (r_state == ST_IDLE);

    jtag_halt_timer #(
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_halt_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == ST_IDLE),
        .i_enable (r_state == ST_HALT_WAIT),
        .o_tc     (w_tc)
    );

`ifdef JTAG_GPR_AUTOINC_EN
    reg_addr_t r_ptr;

    assign w_addr_sel = req_inc_i ? r_ptr : req_addr_i;

    // Only a completed access advances the pointer; timeouts leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= reg_addr_t'(1);
        end else if (r_state == ST_ACCESS) begin
            r_ptr <= next_ptr(r_req.addr);
        end
    end
`else
    assign w_addr_sel = req_addr_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_next = ST_HALT_WAIT;
            ST_HALT_WAIT: begin
                if (halted_i)  w_state_next = ST_ACCESS;
                else if (w_tc) w_state_next = ST_RESP;
            end
            ST_ACCESS:    w_state_next = ST_RESP;
            ST_RESP:      if (resp_ready_i) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_data_o  = ZERO_WORD;
        resp_err_o   = 1'b0;
        halt_req_o   = 1'b0;
        jtag_we_o    = WRITE_DISABLE;
        jtag_addr_o  = ZERO_REG;
        jtag_data_o  = ZERO_WORD;
        case (r_state)
            ST_IDLE:      req_ready_o = 1'b1;
            ST_HALT_WAIT: halt_req_o  = 1'b1;
            ST_ACCESS: begin
                halt_req_o  = 1'b1;
                jtag_addr_o = r_req.addr;
                if (r_req.we) begin
                    jtag_we_o   = WRITE_ENABLE;
                    jtag_data_o = r_req.data;
                end
            end
            ST_RESP: begin
                halt_req_o   = 1'b1;
                resp_valid_o = 1'b1;
                resp_data_o  = r_resp_data;
                resp_err_o   = r_resp_err;
            end
            default: ;
        endcase
    end

    // Request latch and response registers; x0 reads are forced to zero here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= '0;
            r_resp_data <= ZERO_WORD;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req       <= '{we: req_we_i, addr: w_addr_sel, data: req_data_i};
                r_resp_data <= ZERO_WORD;
                r_resp_err  <= 1'b0;
            end
            if (r_state == ST_HALT_WAIT && !halted_i && w_tc) begin
                r_resp_err <= 1'b1;
            end
            if (r_state == ST_ACCESS && !r_req.we) begin
                r_resp_data <= (r_req.addr == ZERO_REG) ? ZERO_WORD : jtag_data_i;
            end
        end
    end

endmodule

// File: tb/tb_jtag_gpr_master.sv
// Self-checking bench for jtag_gpr_master: GPR environment model plus a transaction-level reference.
// Define JTAG_GPR_AUTOINC_EN to also exercise the auto-increment pointer.
module tb_jtag_gpr_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [4:0]  req_addr_i = '0;
    logic [31:0] req_data_i = '0;
`ifdef JTAG_GPR_AUTOINC_EN
    logic        req_inc_i = 1'b0;
`endif
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        halt_req_o;
    logic        halted_i = 1'b0;
    logic        jtag_we_o;
    logic [4:0]  jtag_addr_o;
    logic [31:0] jtag_data_o;
    logic [31:0] jtag_data_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] gpr     [32];
    logic [31:0] ref_mem [32];
    logic [4:0]  ref_ptr = 5'd1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          we_cnt;
        logic [4:0]  we_addr;
        int          ctl_bad;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } txn_t;

    always #5 clk = ~clk;

    jtag_gpr_master #(.HALT_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
`ifdef JTAG_GPR_AUTOINC_EN
        .req_inc_i    (req_inc_i),
`endif
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .halt_req_o   (halt_req_o),
        .halted_i     (halted_i),
        .jtag_we_o    (jtag_we_o),
        .jtag_addr_o  (jtag_addr_o),
        .jtag_data_o  (jtag_data_o),
        .jtag_data_i  (jtag_data_i)
    );

    // GPR file environment: x0 reads zero and ignores writes.
    assign jtag_data_i = (jtag_addr_o == 5'd0) ? 32'd0 : gpr[jtag_addr_o];
    always @(posedge clk) if (jtag_we_o && jtag_addr_o != 5'd0) gpr[jtag_addr_o] <= jtag_data_o;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid_i = 1'b0; resp_ready_i = 1'b0; halted_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_ptr = 5'd1;
    endtask

    // One request; the core asserts halted from HALT_WAIT cycle d onward (d >= TO never halts in time).
    task automatic do_txn(input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic inc, input int d, input bit drop, input int stall,
                          input bit no_ack, output txn_t t);
        logic [4:0] a;
        a = addr;
`ifdef JTAG_GPR_AUTOINC_EN
        if (inc) a = ref_ptr;
`endif
        t.exp_err  = (d >= TO);
        t.exp_lat  = t.exp_err ? TO + 1 : d + 3;
        t.exp_we   = (!t.exp_err && we) ? 1 : 0;
        t.exp_data = (t.exp_err || we || a == 5'd0) ? 32'd0 : ref_mem[a];
        if (!t.exp_err) begin
            if (we && a != 5'd0) ref_mem[a] = data;
            ref_ptr = (a == 5'd31) ? 5'd1 : a + 5'd1;
        end
        t.lat = -1; t.we_cnt = 0; t.we_addr = '0; t.ctl_bad = 0; t.data = 'x; t.err = 1'bx;

        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = data;
`ifdef JTAG_GPR_AUTOINC_EN
        req_inc_i = inc;
`endif
        if (req_ready_o !== 1'b1) t.ctl_bad++;
        @(posedge clk);
        #1 req_valid_i = 1'b0; req_addr_i = 5'($urandom); req_data_i = $urandom;
        for (int n = 1; n <= 40 && t.lat < 0; n++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                t.lat = n; t.data = resp_data_o; t.err = resp_err_o;
            end
            if (jtag_we_o) begin
                t.we_cnt++; t.we_addr = jtag_addr_o;
            end
            if (!t.exp_err && n == d + 2) begin
                if (jtag_addr_o !== a || jtag_we_o !== we || jtag_data_o !== (we ? data : 32'd0))
                    t.ctl_bad++;
            end else if (jtag_we_o !== 1'b0 || jtag_addr_o !== 5'd0 || jtag_data_o !== 32'd0) begin
                t.ctl_bad++;
            end
            if (req_ready_o !== 1'b0 || halt_req_o !== 1'b1) t.ctl_bad++;
            halted_i = (n - 1 >= d) && !(drop && n == d + 2);
        end
        if (no_ack) return;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b1 || resp_data_o !== t.data || resp_err_o !== t.err ||
                halt_req_o !== 1'b1 || req_ready_o !== 1'b0) t.ctl_bad++;
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1 resp_ready_i = 1'b0; halted_i = 1'b0;
        @(negedge clk);
        if (resp_valid_o !== 1'b0 || halt_req_o !== 1'b0 || req_ready_o !== 1'b1) t.ctl_bad++;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if ({req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 10000", {req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o});
        end
        n_cmp++;
        if ({resp_data_o, jtag_addr_o, jtag_data_o} !== 69'd0) begin
            n_bad++;
            $display("FAIL reset_data: got resp %h addr %h jdata %h want all 0", resp_data_o, jtag_addr_o, jtag_data_o);
        end
    endtask

    task automatic test_write_read();
        txn_t t;
        halted_i = 1'b1;
        do_txn(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0, 1'b0, t);
        n_cmp++;
        if (t.lat !== 3 || t.err !== 1'b0 || t.data !== 32'd0) begin
            n_bad++;
            $display("FAIL wr5: got lat %0d err %b data %h want lat 3 err 0 data 0", t.lat, t.err, t.data);
        end
        n_cmp++;
        if (t.we_cnt !== 1 || t.we_addr !== 5'd5 || t.ctl_bad !== 0) begin
            n_bad++;
            $display("FAIL wr5_port: got we_cnt %0d addr %0d ctl_bad %0d want 1 5 0", t.we_cnt, t.we_addr, t.ctl_bad);
        end
        halted_i = 1'b1;
        do_txn(1'b0, 5'd5, 32'd0, 1'b0, 0, 1'b1, 0, 1'b0, t);
        n_cmp++;
        if (t.data !== 32'hDEADBEEF || t.err !== 1'b0 || t.lat !== 3 || t.we_cnt !== 0 || t.ctl_bad !== 0) begin
            n_bad++;
            $display("FAIL rd5: got data %h err %b lat %0d we_cnt %0d ctl_bad %0d want deadbeef 0 3 0 0",
                     t.data, t.err, t.lat, t.we_cnt, t.ctl_bad);
        end
    endtask

    task automatic test_timeout();
        txn_t t;
        do_txn(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 1000, 1'b0, 0, 1'b0, t);
        n_cmp++;
        if (t.lat !== TO + 1 || t.err !== 1'b1 || t.data !== 32'd0 || t.we_cnt !== 0 || t.ctl_bad !== 0) begin
            n_bad++;
            $display("FAIL timeout: got lat %0d err %b data %h we_cnt %0d ctl_bad %0d want %0d 1 0 0 0",
                     t.lat, t.err, t.data, t.we_cnt, t.ctl_bad, TO + 1);
        end
    endtask

    task automatic test_addr0();
        txn_t t;
        do_txn(1'b1, 5'd0, 32'h1234, 1'b0, 2, 1'b0, 0, 1'b0, t);
        n_cmp++;
        if (t.we_cnt !== 1 || t.err !== 1'b0 || t.ctl_bad !== 0) begin
            n_bad++;
            $display("FAIL wr0: got we_cnt %0d err %b ctl_bad %0d want 1 0 0", t.we_cnt, t.err, t.ctl_bad);
        end
        do_txn(1'b0, 5'd0, 32'd0, 1'b0, 1, 1'b0, 0, 1'b0, t);
        n_cmp++;
        if (t.data !== 32'd0 || t.err !== 1'b0 || t.lat !== 4) begin
            n_bad++;
            $display("FAIL rd0: got data %h err %b lat %0d want 0 0 4", t.data, t.err, t.lat);
        end
    endtask

    task automatic test_resp_stall();
        txn_t t;
        do_txn(1'b0, 5'd5, 32'd0, 1'b0, 3, 1'b0, 10, 1'b0, t);
        n_cmp++;
        if (t.data !== 32'hDEADBEEF || t.ctl_bad !== 0) begin
            n_bad++;
            $display("FAIL stall: got data %h ctl_bad %0d want deadbeef 0", t.data, t.ctl_bad);
        end
    endtask

    task automatic test_rst_mid();
        txn_t t;
        int   we_seen;
        we_seen = 0;
        @(negedge clk);
        halted_i = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 5'd7; req_data_i = 32'h77777777;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (jtag_we_o) we_seen++;
        end
        n_cmp++;
        if (halt_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_hw_pre: got halt_req %b want 1", halt_req_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; ref_ptr = 5'd1;
        @(negedge clk);
        if (jtag_we_o) we_seen++;
        n_cmp++;
        if ({req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o} !== 5'b10000 || resp_data_o !== 32'd0 || we_seen !== 0) begin
            n_bad++;
            $display("FAIL rst_hw: got ctl %b data %h we_seen %0d want 10000 0 0",
                     {req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o}, resp_data_o, we_seen);
        end
        do_txn(1'b0, 5'd7, 32'd0, 1'b0, 0, 1'b0, 0, 1'b1, t);
        n_cmp++;
        if (t.data !== t.exp_data || resp_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rd7: got data %h valid %b want %h 1", t.data, resp_valid_o, t.exp_data);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; ref_ptr = 5'd1; halted_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o} !== 5'b10000 || resp_data_o !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_resp: got ctl %b data %h want 10000 0",
                     {req_ready_o, resp_valid_o, resp_err_o, halt_req_o, jtag_we_o}, resp_data_o);
        end
    endtask

`ifdef JTAG_GPR_AUTOINC_EN
    task automatic test_autoinc();
        txn_t t;
        logic [4:0] want [3];
        want[0] = 5'd30; want[1] = 5'd31; want[2] = 5'd1;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, (i == 0) ? 5'd30 : 5'd12, 32'hA000_0000 + 32'(i), (i != 0), 0, 1'b0, 0, 1'b0, t);
            n_cmp++;
            if (t.we_addr !== want[i] || t.we_cnt !== 1) begin
                n_bad++;
                $display("FAIL autoinc[%0d]: got addr %0d we_cnt %0d want %0d 1", i, t.we_addr, t.we_cnt, want[i]);
            end
        end
        do_txn(1'b0, 5'd31, 32'd0, 1'b0, 0, 1'b0, 0, 1'b0, t);
        n_cmp++;
        if (t.data !== 32'hA000_0001) begin
            n_bad++;
            $display("FAIL autoinc_rd31: got %h want a0000001", t.data);
        end
    endtask
`endif

    task automatic test_random();
        txn_t t;
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), 5'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 9)),
                   1'($urandom), int'($urandom_range(0, 3)), 1'b0, t);
            n_cmp++;
            if (t.data !== t.exp_data || t.err !== t.exp_err) begin
                n_bad++;
                $display("FAIL rnd_resp[%0d]: got data %h err %b want %h %b", i, t.data, t.err, t.exp_data, t.exp_err);
            end
            n_cmp++;
            if (t.lat !== t.exp_lat) begin
                n_bad++;
                $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, t.lat, t.exp_lat);
            end
            n_cmp++;
            if (t.we_cnt !== t.exp_we || t.ctl_bad !== 0) begin
                n_bad++;
                $display("FAIL rnd_port[%0d]: got we_cnt %0d ctl_bad %0d want %0d 0", i, t.we_cnt, t.ctl_bad, t.exp_we);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            gpr[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        test_reset();
        test_write_read();
        test_timeout();
        test_addr0();
        test_resp_stall();
        test_rst_mid();
`ifdef JTAG_GPR_AUTOINC_EN
        test_autoinc();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
